// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_ctrl_pkg;

    localparam int BAUD_W      = 3;
    localparam int DATA_W      = 8;
    localparam int ID_W        = 3;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WRITE,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (wrapping) for the first set request.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned j;
        j     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j[IDX_W-1:0]]) begin
                valid                = 1'b1;
                grant[j[IDX_W-1:0]]  = 1'b1;
                idx                  = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between N_REQ byte requesters.
// Define UART_TX_TIMEOUT_EN to abort a frame whose Tx_BUSY never rises and pulse err.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [BAUD_W-1:0]         baud_cfg,
    input  logic [N_REQ-1:0]          req,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         Tx_DATA,
    output logic [BAUD_W-1:0]         baud_select,
    output logic                      Tx_WR,
    output logic                      Tx_EN,
    input  logic                      Tx_BUSY,
    output logic [ID_W-1:0]           active_id,
    output logic                      err
);

    localparam int PTR_W = $clog2(N_REQ);

    tx_state_t          state;
    logic [PTR_W-1:0]   ptr;
    logic [N_REQ-1:0]   gnt_r;
    logic [N_REQ-1:0]   req_live;
    logic [N_REQ-1:0]   arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;

    // A requester being acked this cycle still holds req; keep it out of the idle wake-up test.
    assign req_live = req & ~ack;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

`ifdef UART_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] to_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= PTR_W'(N_REQ - 1);
            gnt_r       <= '0;
            ack         <= '0;
            Tx_DATA     <= '0;
            baud_select <= '0;
            Tx_WR       <= 1'b0;
            Tx_EN       <= 1'b0;
            active_id   <= '0;
`ifdef UART_TX_TIMEOUT_EN
            err         <= 1'b0;
            to_cnt      <= '0;
`endif
        end else begin
            Tx_EN <= enable;
            Tx_WR <= 1'b0;
            ack   <= '0;
`ifdef UART_TX_TIMEOUT_EN
            err   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    baud_select <= baud_cfg;
                    if (enable && |req_live && !Tx_BUSY)
                        state <= GRANT;
                end
                GRANT: begin
                    // A request withdrawn before this point is simply not served.
                    if (arb_valid) begin
                        Tx_DATA   <= req_data[int'(arb_idx)*DATA_W +: DATA_W];
                        active_id <= ID_W'(arb_idx);
                        ptr       <= arb_idx;
                        gnt_r     <= arb_grant;
                        Tx_WR     <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    state <= WAIT_BUSY;
`ifdef UART_TX_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_BUSY: begin
`ifdef UART_TX_TIMEOUT_EN
                    // Expiry lands err exactly TIMEOUT cycles after the Tx_WR cycle.
                    if (Tx_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == CNT_W'(TIMEOUT - 2)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`else
                    if (Tx_BUSY)
                        state <= WAIT_DONE;
`endif
                end
                WAIT_DONE: begin
                    if (!Tx_BUSY) begin
                        ack   <= gnt_r;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural transmitter busy model.
module tb_uart_tx_scheduler;
    import uart_ctrl_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [2:0]        baud_cfg;
    logic [N-1:0]      req;
    logic [8*N-1:0]    req_data;
    logic [N-1:0]      ack;
    logic [7:0]        Tx_DATA;
    logic [2:0]        baud_select;
    logic              Tx_WR;
    logic              Tx_EN;
    logic              tx_busy;
    logic [2:0]        active_id;
    logic              err;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(N), .TIMEOUT(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .baud_cfg    (baud_cfg),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .Tx_DATA     (Tx_DATA),
        .baud_select (baud_select),
        .Tx_WR       (Tx_WR),
        .Tx_EN       (Tx_EN),
        .Tx_BUSY     (tx_busy),
        .active_id   (active_id),
        .err         (err)
    );

    typedef struct {
        logic [7:0] data;
        int         id;
        logic [2:0] baud;
        bit         want_ack;
    } frame_t;

    frame_t exp_q[$];
    int     ack_q[$];
    int     checks = 0;
    int     errors = 0;
    logic [2:0] exp_baud;
    bit     force_idle = 1'b0;
    int     err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy rises the edge after a write, lasts a baud-dependent length.
    int busy_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_busy) begin
            if (busy_cnt <= 1) tx_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end else if (Tx_WR && !force_idle) begin
            tx_busy  <= 1'b1;
            busy_cnt <= 10 + 4 * (7 - int'(baud_select));
        end
    end

    // Monitor: frames checked on Tx_WR, acks checked against the frames that went out.
    logic prev_wr = 1'b0;
    logic prev_busy = 1'b0;
    int   since_fall = 99;
    always @(negedge clk) begin
        frame_t f;
        int id;
        if (reset) begin
            ack_q.delete();
            check("ack_in_reset", 32'(ack), 32'(0));
            check("wr_in_reset", 32'(Tx_WR), 32'(0));
            prev_wr   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !tx_busy) since_fall = 0;
            else if (since_fall < 99) since_fall++;
            if (Tx_WR) begin
                check("wr_single_cycle", 32'(prev_wr), 32'(0));
                check("wr_while_busy", 32'(tx_busy), 32'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 32'(Tx_WR), 32'(0));
                end else begin
                    f = exp_q.pop_front();
                    check("tx_data", 32'(Tx_DATA), 32'(f.data));
                    check("active_id", 32'(active_id), 32'(f.id));
                    check("baud_select", 32'(baud_select), 32'(f.baud));
                    if (f.want_ack) ack_q.push_back(f.id);
                end
            end
            if (ack != '0) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'(0));
                end else begin
                    id = ack_q.pop_front();
                    check("ack_id", 32'(ack), 32'(1) << id);
                    check("ack_latency", 32'(since_fall), 32'(1));
                end
            end
            if (err) err_cnt++;
            prev_wr   = Tx_WR;
            prev_busy = tx_busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input int i, input logic [7:0] d, input bit want_ack);
        frame_t f;
        f.data = d; f.id = i; f.baud = exp_baud; f.want_ack = want_ack;
        exp_q.push_back(f);
    endtask

    task automatic post(input int i, input logic [7:0] d, input bit want_ack);
        req_data[i*8 +: 8] = d;
        req[i] = 1'b1;
        expect_frame(i, d, want_ack);
    endtask

    // Requesters hold req until their ack; wait for everything outstanding to finish.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !(req == '0 && ack_q.size() == 0 && exp_q.size() == 0)) begin
            tick(1);
            req = req & ~ack;
            n++;
        end
        check("drain_done", 32'(n < budget), 32'(1));
    endtask

    task automatic wait_wr(input int budget, output int lat);
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!Tx_WR && lat < budget);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"},   32'(Tx_WR),       32'(0));
        check({tag, "_ack"},  32'(ack),         32'(0));
        check({tag, "_en"},   32'(Tx_EN),       32'(0));
        check({tag, "_id"},   32'(active_id),   32'(0));
        check({tag, "_baud"}, 32'(baud_select), 32'(0));
        check({tag, "_data"}, 32'(Tx_DATA),     32'(0));
        check({tag, "_err"},  32'(err),         32'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int wr_cnt;
        reset    = 1'b1;
        enable   = 1'b0;
        baud_cfg = 3'b111;
        req      = '0;
        req_data = '0;
        exp_baud = 3'b111;
        tick(3);
        check_all_zero("reset");
        reset  = 1'b0;
        enable = 1'b1;
        tick(3);
        check("tx_en_follows", 32'(Tx_EN), 32'(1));
        check("baud_loaded", 32'(baud_select), 32'(3'b111));

        // Single requester 0
        post(0, 8'h9A, 1'b1);
        wait_wr(20, lat);
        check("t1_wr_latency", 32'(lat), 32'(2));
        drain(500);

        // All four requesting from a fresh pointer: order 0,1,2,3
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
        post(0, 8'h11, 1'b1);
        post(1, 8'h22, 1'b1);
        post(2, 8'h33, 1'b1);
        post(3, 8'h44, 1'b1);
        drain(2000);

        // Baud change mid-frame takes effect only after returning to idle
        post(1, 8'h55, 1'b1);
        wait_wr(20, lat);
        baud_cfg = 3'b110;
        tick(5);
        check("t3_baud_hold", 32'(baud_select), 32'(3'b111));
        drain(500);
        tick(2);
        check("t3_baud_new", 32'(baud_select), 32'(3'b110));
        exp_baud = 3'b110;
        post(2, 8'h66, 1'b1);
        drain(500);

        // Reset while waiting for the frame to finish
        post(3, 8'h77, 1'b1);
        lat = 0;
        while (!tx_busy && lat < 50) begin
            tick(1);
            lat++;
        end
        check("t4_busy_seen", 32'(tx_busy), 32'(1));
        tick(3);
        reset = 1'b1;
        #1;
        check_all_zero("t4_async");
        req = '0;
        tick(3);
        reset = 1'b0;
        tick(2);
        post(3, 8'h78, 1'b1);
        drain(500);

        // enable low blocks new grants
        enable = 1'b0;
        tick(2);
        req_data[2*8 +: 8] = 8'hA5;
        req[2] = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (Tx_WR) wr_cnt++;
        end
        check("t5_no_wr", 32'(wr_cnt), 32'(0));
        check("t5_tx_en_low", 32'(Tx_EN), 32'(0));
        expect_frame(2, 8'hA5, 1'b1);
        enable = 1'b1;
        drain(500);

`ifdef UART_TX_TIMEOUT_EN
        // Transmitter never goes busy: err after TIMEOUT cycles, no ack
        force_idle = 1'b1;
        post(0, 8'hC3, 1'b0);
        wait_wr(20, lat);
        lat = 0;
        while (!err && lat < 100) begin
            tick(1);
            lat++;
        end
        req = '0;
        check("t6_err_latency", 32'(lat), 32'(32));
        force_idle = 1'b0;
        tick(3);
        post(1, 8'hC4, 1'b1);
        drain(500);
        check("t6_err_count", 32'(err_cnt), 32'(1));
`else
        check("err_never", 32'(err_cnt), 32'(0));
`endif

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
